// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, write-back bypass and a reset clear sweep.
// Optional producer tags are enabled by defining REGFILE_SB_TAG_EN.

module regfile_sb_rd #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                          run,
  input  logic [AW-1:0]                 addr,
  input  logic                          wb_en,
  input  logic [AW-1:0]                 wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          wb_clr,
  input  logic [2**AW-1:0][XLEN-1:0]    mem,
  input  logic [2**AW-1:0]              busy_arr,
  output logic [XLEN-1:0]               data,
  output logic                          busy
);
  localparam bit ZR = (ZERO_REG != 0);

  always_comb begin
    // Outside RUN the port reads zero and reports busy so issue stalls.
    data = '0;
    busy = 1'b1;
    if (run) begin
      if (ZR && addr == '0) begin
        data = '0;
        busy = 1'b0;
      end else if (wb_en && wb_addr == addr) begin
        data = wb_data;
        busy = wb_clr ? 1'b0 : busy_arr[addr];
      end else begin
        data = mem[addr];
        busy = busy_arr[addr];
      end
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int TAGW     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic [TAGW-1:0] issue_tag,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [TAGW-1:0] wb_tag
);
  localparam int NREG = 2**AW;
  localparam int NRD  = 2;
  localparam bit ZR   = (ZERO_REG != 0);

  typedef enum logic {INIT, RUN} state_t;

  state_t                    state, state_nxt;
  logic [AW-1:0]             cnt, cnt_nxt;
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           busy;
  logic                      run, tag_ok, wb_we, iss_we, wb_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == AW'(NREG-1)) state_nxt = RUN;
    end
  end

  assign run   = (state == RUN);
  assign ready = run;

`ifdef REGFILE_SB_TAG_EN
  logic [NREG-1:0][TAGW-1:0] tag;

  // Only the most recent producer of a register may retire its busy bit.
  assign tag_ok = (wb_tag == tag[wb_addr]);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT)  tag[cnt]      <= '0;
      else if (iss_we)    tag[issue_rd] <= issue_tag;
    end
  end
`else
  logic unused_tag;
  assign unused_tag = ^{issue_tag, wb_tag};
  assign tag_ok     = 1'b1;
`endif

  assign wb_we  = run && wb_en    && !(ZR && wb_addr  == '0);
  assign iss_we = run && issue_en && !(ZR && issue_rd == '0);
  assign wb_clr = wb_en && tag_ok;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[cnt]  <= '0;
        busy[cnt] <= 1'b0;
      end else begin
        if (wb_we)          mem[wb_addr]   <= wb_data;
        if (wb_we && tag_ok) busy[wb_addr] <= 1'b0;
        // Later assignment wins: a same-cycle issue supersedes the retiring producer.
        if (iss_we)         busy[issue_rd] <= 1'b1;
      end
    end
  end

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;

  assign rd_addr = {rs2_addr, rs1_addr};

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      regfile_sb_rd #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
        .run      (run),
        .addr     (rd_addr[g]),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_clr   (wb_clr),
        .mem      (mem),
        .busy_arr (busy),
        .data     (rd_data[g]),
        .busy     (rd_busy[g])
      );
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];
endmodule
